abr_ntt_add_sub_ctrl: RTL
=========================

# abr_ntt_add_sub_ctrl

Sequencer that runs one full polynomial coefficient-wise modular add or subtract, dst[i] = (a[i] ± b[i]) mod q for i = 0..NUM_COEFF-1. It reads operand pairs from the two NTT source memory ports and streams them into the shared modular add/sub unit at one coefficient per cycle. Results are written back to the destination memory port. It sits between the NTT top-level control (start/done) and the add/sub datapath plus memory interfaces.

## Interface
- REG_SIZE, 24: coefficient width.
- ADDR_W, 8: memory address width.
- NUM_COEFF, 256: coefficients per operation; must be ≥1.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- zeroize  in  1  synchronous clear to IDLE, all regs 0
- start_i  in  1  one-cycle start request
- sub_i, mlkem_i  in  1  mode; latched at accepted start
- src_a_base_i, src_b_base_i, dst_base_i  in  ADDR_W  base addresses; latched at start
- stall_i  in  1  global pipeline freeze (memory backpressure)
- rd_en_o  out  1; rd_addr_a_o, rd_addr_b_o  out  ADDR_W: shared read strobe
- rd_data_a_i, rd_data_b_i  in  REG_SIZE: valid exactly 1 cycle after rd_en_o
- as_en_o, as_sub_o, as_mlkem_o  out  1: add/sub unit control
- as_opa_o, as_opb_o  out  REG_SIZE: operands; as_prime is tied outside
- as_res_i  in  REG_SIZE: add/sub result, valid the cycle after as_en_o
- wr_en_o  out  1; wr_addr_o  out  ADDR_W; wr_data_o  out  REG_SIZE: destination write
- busy_o  out  1 high outside IDLE; done_o  out  1 one-cycle completion pulse

## Operation
- FSM states:
  - IDLE: start_i accepted → RUN; latch modes and bases; rd_idx = wr_idx = 0.
  - RUN: when rd_idx reaches NUM_COEFF → DRAIN.
  - DRAIN: when the last write issues → DONE.
  - DONE: 1 cycle, done_o = 1 → IDLE.
- start_i is ignored outside IDLE.
- Stage 0 (read):
  - In RUN with !stall_i and rd_idx < NUM_COEFF, assert rd_en_o.
  - rd_addr_a_o = src_a_base + rd_idx and rd_addr_b_o = src_b_base + rd_idx, both mod 2^ADDR_W.
  - rd_idx increments.
- Stage 1 (compute):
  - Valid the cycle after a read.
  - If !stall_i: assert as_en_o; as_opa_o/as_opb_o = the read data, or the hold register if it is valid.
  - If stall_i: capture the read data into a 1-entry hold register (only on the arrival cycle) and keep stage 1 valid.
- Stage 2 (write):
  - Valid the cycle after as_en_o.
  - If !stall_i: wr_en_o = 1, wr_data_o = as_res_i, wr_addr_o = dst_base + wr_idx; wr_idx increments.
  - If stall_i: hold. The datapath output stays stable because as_en_o is low.
- stall_i freezes all three stages in the same cycle. No strobe (rd_en_o, as_en_o, wr_en_o) is asserted while stall_i = 1.
- Stage 1 and stage 2 advance together. A coefficient in stage 2 writes in the same cycle that stage 1 issues the next as_en_o.
- as_sub_o and as_mlkem_o are driven from the latched mode for the whole operation.
- Mode and base inputs may change after start without effect.
- Read and write indices wrap modulo 2^ADDR_W; there is no error on overflow.
- reset_n or zeroize mid-operation:
  - Immediate return to IDLE; all strobes low; hold register invalid.
  - No done_o pulse; partially written memory is left as-is.

## Timing
- Reset values: every output 0; state IDLE.
- start_i at cycle 0:
  - First rd_en_o in cycle 1, first as_en_o in cycle 2, first wr_en_o in cycle 3.
  - Without stalls: last wr_en_o in cycle NUM_COEFF+2, done_o in cycle NUM_COEFF+3, busy_o low in cycle NUM_COEFF+4.
- Each stall_i cycle adds exactly 1 cycle to total latency.
- Sustained throughput: 1 coefficient/cycle.
- A new start_i is accepted in the first cycle after done_o.

## Test plan
- Add, MLDSA (q = 8380417), NUM_COEFF = 256: a[i] = i, b[i] = q-1.
  - Response: dst[i] = (i+q-1) mod q (dst[0] = 8380416, dst[1] = 0); 256 writes in cycles 3..258; done_o in cycle 259.
- Sub, MLKEM (q = 3329): a[i] = 5, b[i] = 10.
  - Response: every dst = 3324; as_mlkem_o = as_sub_o = 1 throughout.
- stall_i high for cycles 10-14 and for 3 cycles ending on the last read.
  - Response: no strobes during stalls; results identical to the unstalled run; done_o 8 cycles later than unstalled.
- dst_base = 250, src_a_base = 200, NUM_COEFF = 16.
  - Response: writes to 250..255 then 0..9; reads wrap correctly.
- start_i pulsed again during RUN with different modes/bases.
  - Response: ignored; the original operation completes unchanged.
- zeroize in cycle 50 of a run, then start_i in cycle 52.
  - Response: all outputs 0 in cycle 51; no done_o for the aborted run; the new run completes normally.

Source files
------------

// File: rtl/abr_ntt_add_sub_ctrl.sv
// Sequencer for a full-polynomial coefficient-wise modular add/sub.
// Three-stage read / compute / write pipeline; stall_i freezes all stages at once.
module abr_ntt_add_sub_ctrl #(
    parameter int REG_SIZE  = 24,
    parameter int ADDR_W    = 8,
    parameter int NUM_COEFF = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                zeroize,
    input  logic                start_i,
    input  logic                sub_i,
    input  logic                mlkem_i,
    input  logic [ADDR_W-1:0]   src_a_base_i,
    input  logic [ADDR_W-1:0]   src_b_base_i,
    input  logic [ADDR_W-1:0]   dst_base_i,
    input  logic                stall_i,
    output logic                rd_en_o,
    output logic [ADDR_W-1:0]   rd_addr_a_o,
    output logic [ADDR_W-1:0]   rd_addr_b_o,
    input  logic [REG_SIZE-1:0] rd_data_a_i,
    input  logic [REG_SIZE-1:0] rd_data_b_i,
    output logic                as_en_o,
    output logic                as_sub_o,
    output logic                as_mlkem_o,
    output logic [REG_SIZE-1:0] as_opa_o,
    output logic [REG_SIZE-1:0] as_opb_o,
    input  logic [REG_SIZE-1:0] as_res_i,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [REG_SIZE-1:0] wr_data_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int CNT_W = $clog2(NUM_COEFF + 1);
    localparam logic [CNT_W-1:0] C_RD_LAST = CNT_W'(NUM_COEFF);
    localparam logic [CNT_W-1:0] C_WR_LAST = CNT_W'(NUM_COEFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_sub;
    logic                  r_mlkem;
    logic [ADDR_W-1:0]     r_rd_addr_a;
    logic [ADDR_W-1:0]     r_rd_addr_b;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic                  r_s1_valid;
    logic                  r_s2_valid;
    logic                  r_hold_valid;
    logic [REG_SIZE-1:0]   r_hold_a;
    logic [REG_SIZE-1:0]   r_hold_b;

    logic                  w_start;
    logic                  w_rd_en;
    logic                  w_as_en;
    logic                  w_wr_en;

    // Strobes are also suppressed in a zeroize cycle so an abort never issues a partial access.
    assign w_start = (r_state == ST_IDLE) && start_i;
    assign w_rd_en = (r_state == ST_RUN) && !stall_i && !zeroize && (r_rd_cnt != C_RD_LAST);
    assign w_as_en = r_s1_valid && !stall_i && !zeroize;
    assign w_wr_en = r_s2_valid && !stall_i && !zeroize;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_next = ST_RUN;
            ST_RUN:   if (r_rd_cnt == C_RD_LAST) w_next = ST_DRAIN;
            ST_DRAIN: if (w_wr_en && (r_wr_cnt == C_WR_LAST)) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else if (zeroize) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sub        <= 1'b0;
            r_mlkem      <= 1'b0;
            r_rd_addr_a  <= '0;
            r_rd_addr_b  <= '0;
            r_wr_addr    <= '0;
            r_rd_cnt     <= '0;
            r_wr_cnt     <= '0;
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_a     <= '0;
            r_hold_b     <= '0;
        end else if (zeroize) begin
            r_sub        <= 1'b0;
            r_mlkem      <= 1'b0;
            r_rd_addr_a  <= '0;
            r_rd_addr_b  <= '0;
            r_wr_addr    <= '0;
            r_rd_cnt     <= '0;
            r_wr_cnt     <= '0;
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_a     <= '0;
            r_hold_b     <= '0;
        end else begin
            if (w_start) begin
                r_sub       <= sub_i;
                r_mlkem     <= mlkem_i;
                r_rd_addr_a <= src_a_base_i;
                r_rd_addr_b <= src_b_base_i;
                r_wr_addr   <= dst_base_i;
                r_rd_cnt    <= '0;
                r_wr_cnt    <= '0;
            end
            if (w_rd_en) begin
                r_rd_addr_a <= r_rd_addr_a + ADDR_W'(1);
                r_rd_addr_b <= r_rd_addr_b + ADDR_W'(1);
                r_rd_cnt    <= r_rd_cnt + CNT_W'(1);
            end
            if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
                r_wr_cnt  <= r_wr_cnt + CNT_W'(1);
            end
            // Read data is only valid on its arrival cycle, so a stall must capture it then.
            if (!stall_i) begin
                r_s1_valid   <= w_rd_en;
                r_s2_valid   <= w_as_en;
                r_hold_valid <= 1'b0;
            end else if (r_s1_valid && !r_hold_valid) begin
                r_hold_valid <= 1'b1;
                r_hold_a     <= rd_data_a_i;
                r_hold_b     <= rd_data_b_i;
            end
        end
    end

    assign rd_en_o     = w_rd_en;
    assign rd_addr_a_o = w_rd_en ? r_rd_addr_a : '0;
    assign rd_addr_b_o = w_rd_en ? r_rd_addr_b : '0;
    assign as_en_o     = w_as_en;
    assign as_sub_o    = r_sub;
    assign as_mlkem_o  = r_mlkem;
    assign as_opa_o    = !w_as_en ? '0 : (r_hold_valid ? r_hold_a : rd_data_a_i);
    assign as_opb_o    = !w_as_en ? '0 : (r_hold_valid ? r_hold_b : rd_data_b_i);
    assign wr_en_o     = w_wr_en;
    assign wr_addr_o   = w_wr_en ? r_wr_addr : '0;
    assign wr_data_o   = w_wr_en ? as_res_i : '0;
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = (r_state == ST_DONE);

endmodule
